// File: rtl/nes_pad_pkg.sv
// Shared definitions for the NES/Famicom gamepad reader.
//   state_t          : reader FSM states
//   DEF_*            : default timing for a 50 MHz system clock
//   BTN_*            : bit positions of each button in the active-low
//                      button byte (Gigatron serial input ordering)
package nes_pad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;

    // 6 us half-bit phase and ~60 Hz poll rate at 50 MHz.
    localparam int DEF_CLK_DIV     = 300;
    localparam int DEF_POLL_PERIOD = 833333;
    localparam int DEF_NBITS       = 8;

    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

endpackage

// File: rtl/nes_pad_reader_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
//   clk_i   : destination clock
//   rst_n_i : asynchronous active-low reset; output resets to 1 (line idle)
//   d_i     : asynchronous input
//   q_o     : synchronised output, two cycles of latency
module sync_2ff (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/nes_pad_reader.sv
// Host-side reader for the NES/Famicom serial gamepad.
// Pulses LATCH, clocks PULSE, shifts in DATA MSB first and publishes an
// active-low button byte. Polls automatically every POLL_PERIOD cycles and
// also on a manual start request.
//   CLOCK_50  : system clock
//   reset_n   : asynchronous active-low reset
//   start     : one-cycle manual poll request
//   PAD_DATA  : serial data from pad, active-low, asynchronous
//   PAD_LATCH : latch to pad (registered)
//   PAD_PULSE : shift clock to pad (registered)
//   buttons   : last complete frame, first bit read in buttons[NBITS-1]
//   valid     : one-cycle strobe coincident with a buttons update
//   busy      : high while LATCH/LOW/HIGH are in progress
// CLK_DIV must be >= 4 so the synchroniser latency fits inside a LOW phase;
// POLL_PERIOD must exceed one frame (17*CLK_DIV for 8 bits).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | both pad lines low, waiting for a pending poll request
// ST_LATCH | PAD_LATCH high for two phases
// ST_LOW   | both lines low for one phase; data sampled on its last cycle
// ST_HIGH  | PAD_PULSE high for one phase; pad shifts to its next bit
// ST_DONE  | one cycle: valid strobe, new byte visible on buttons
module nes_pad_reader
    import nes_pad_pkg::*;
#(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int POLL_PERIOD = DEF_POLL_PERIOD,
    parameter int NBITS       = DEF_NBITS
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             start,
    input  logic             PAD_DATA,
    output logic             PAD_LATCH,
    output logic             PAD_PULSE,
    output logic [NBITS-1:0] buttons,
    output logic             valid,
    output logic             busy
);

    localparam int PHW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PLW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int BIW = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [PHW-1:0] PH_LAST   = PHW'(CLK_DIV - 1);
    localparam logic [PLW-1:0] POLL_LAST = PLW'(POLL_PERIOD - 1);
    localparam logic [BIW-1:0] BIT_LAST  = BIW'(NBITS - 1);

    state_t           state_q, state_d;
    logic [PHW-1:0]   phase_q, phase_d, phase_nxt;
    logic             lap_q, lap_d;
    logic [BIW-1:0]   bit_q, bit_d;
    logic [PLW-1:0]   poll_q;
    logic             pend_q, pend_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic [NBITS-1:0] buttons_q, buttons_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             latch_q, latch_d;
    logic             pulse_q, pulse_d;
    logic             phase_last;
    logic             poll_wrap;
    logic             accept;
    logic             data_s;

    sync_2ff u_sync (
        .clk_i   (CLOCK_50),
        .rst_n_i (reset_n),
        .d_i     (PAD_DATA),
        .q_o     (data_s)
    );

    assign poll_wrap  = (poll_q == POLL_LAST);
    assign phase_last = (phase_q == PH_LAST);
    assign phase_nxt  = phase_last ? '0 : phase_q + PHW'(1);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            poll_q <= '0;
        end else begin
            poll_q <= poll_wrap ? '0 : poll_q + PLW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            lap_q     <= 1'b0;
            bit_q     <= '0;
            pend_q    <= 1'b0;
            shift_q   <= '1;
            buttons_q <= '1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            lap_q     <= lap_d;
            bit_q     <= bit_d;
            pend_q    <= pend_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            latch_q   <= latch_d;
            pulse_q   <= pulse_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        lap_d     = lap_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        valid_d   = 1'b0;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                lap_d   = 1'b0;
                if (pend_q) begin
                    accept  = 1'b1;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                // Two phases: lap_q marks the second one.
                phase_d = phase_nxt;
                if (phase_last) begin
                    lap_d = 1'b1;
                    if (lap_q) begin
                        lap_d   = 1'b0;
                        bit_d   = '0;
                        state_d = ST_LOW;
                    end
                end
            end
            ST_LOW: begin
                phase_d = phase_nxt;
                if (phase_last) begin
                    shift_d = {shift_q[NBITS-2:0], data_s};
                    if (bit_q == BIT_LAST) begin
                        // Publish on the same edge as the last sample so that
                        // buttons is already updated while valid is high.
                        buttons_d = {shift_q[NBITS-2:0], data_s};
                        valid_d   = 1'b1;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_HIGH;
                    end
                end
            end
            ST_HIGH: begin
                phase_d = phase_nxt;
                if (phase_last) begin
                    bit_d   = bit_q + BIW'(1);
                    state_d = ST_LOW;
                end
            end
            ST_DONE: begin
                phase_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new request on the acceptance cycle wins, so it is not lost.
        pend_d  = (pend_q & ~accept) | start | poll_wrap;

        // Outputs are registered from the next state to keep pad lines glitch-free.
        busy_d  = (state_d == ST_LATCH) || (state_d == ST_LOW) || (state_d == ST_HIGH);
        latch_d = (state_d == ST_LATCH);
        pulse_d = (state_d == ST_HIGH);
    end

    assign PAD_LATCH = latch_q;
    assign PAD_PULSE = pulse_q;
    assign buttons   = buttons_q;
    assign valid     = valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader. Two instances share clock and reset:
//   dut_p : POLL_PERIOD=200, PAD_DATA tied high (disconnected pad)
//   dut_m : very long POLL_PERIOD, driven by manual starts and a pad model
module tb_nes_pad_reader;

    localparam int C         = 4;
    localparam int NB        = 8;
    localparam int POLL_P    = 200;
    localparam int POLL_M    = 1_000_000;
    localparam int FRAME_LEN = 2*C + NB*C + (NB-1)*C + 1;
    localparam int BUSY_LEN  = FRAME_LEN - 1;
    localparam int NFRAMES   = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          start_p, start_m;
    logic          pad_one;
    logic          pad_data_m;
    logic          latch_p, pulse_p, valid_p, busy_p;
    logic          latch_m, pulse_m, valid_m, busy_m;
    logic [NB-1:0] buttons_p, buttons_m;

    logic [7:0]    pad_byte = 8'hFF;
    logic [7:0]    pad_sr = 8'hFF;
    logic          pulse_prev = 1'b0;
    logic          ovr_en, ovr_val;

    int n_cmp = 0;
    int n_bad = 0;

    nes_pad_reader #(.CLK_DIV(C), .POLL_PERIOD(POLL_P), .NBITS(NB)) dut_p (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .start    (start_p),
        .PAD_DATA (pad_one),
        .PAD_LATCH(latch_p),
        .PAD_PULSE(pulse_p),
        .buttons  (buttons_p),
        .valid    (valid_p),
        .busy     (busy_p)
    );

    nes_pad_reader #(.CLK_DIV(C), .POLL_PERIOD(POLL_M), .NBITS(NB)) dut_m (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .start    (start_m),
        .PAD_DATA (pad_data_m),
        .PAD_LATCH(latch_m),
        .PAD_PULSE(pulse_m),
        .buttons  (buttons_m),
        .valid    (valid_m),
        .busy     (busy_m)
    );

    // Controller-side shift register: parallel load while latched,
    // shift toward bit 7 on each PULSE rise, ones shifted in.
    always @(posedge clk) begin
        pulse_prev <= pulse_m;
        if (latch_m)
            pad_sr <= pad_byte;
        else if (pulse_m && !pulse_prev)
            pad_sr <= {pad_sr[6:0], 1'b1};
    end

    assign pad_data_m = ovr_en ? ovr_val : pad_sr[7];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start_m();
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
    endtask

    // Watches one dut_m frame from the busy rise (n=0) to the valid strobe.
    task automatic mon_m(output int latch_hi, output int pulse_runs, output int bad_run,
                         output int valid_at, output int busy_hi, output int overlap,
                         output int bad_idle, output logic [7:0] btn, output bit timeout);
        int n;
        int run;
        latch_hi = 0; pulse_runs = 0; bad_run = 0; valid_at = -1;
        busy_hi = 0; overlap = 0; bad_idle = 0; btn = 8'h00; timeout = 1'b0;
        run = 0;
        n = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy_m) begin
                n = 0;
                break;
            end
            if (pulse_m || latch_m) bad_idle++;
        end
        if (n < 0) begin
            timeout = 1'b1;
            return;
        end
        while (n < 200) begin
            if (latch_m) latch_hi++;
            if (latch_m && pulse_m) overlap++;
            if (pulse_m) run++;
            else if (run != 0) begin
                pulse_runs++;
                if (run != C) bad_run++;
                run = 0;
            end
            if (busy_m) busy_hi++;
            if (pulse_m && !busy_m) bad_idle++;
            if (valid_m) begin
                valid_at = n;
                btn = buttons_m;
                break;
            end
            @(negedge clk);
            n++;
        end
        if (valid_at < 0) timeout = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({latch_p, pulse_p, buttons_p, valid_p, busy_p} !== {2'b00, 8'hFF, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_p: got latch=%b pulse=%b buttons=%h valid=%b busy=%b, expected 0 0 ff 0 0",
                     latch_p, pulse_p, buttons_p, valid_p, busy_p);
        end
        n_cmp++;
        if ({latch_m, pulse_m, buttons_m, valid_m, busy_m} !== {2'b00, 8'hFF, 2'b00}) begin
            n_bad++;
            $display("FAIL reset_m: got latch=%b pulse=%b buttons=%h valid=%b busy=%b, expected 0 0 ff 0 0",
                     latch_m, pulse_m, buttons_m, valid_m, busy_m);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_latch();
        bit seen;
        bit bad_seen;
        seen = 1'b0;
        bad_seen = 1'b0;
        start_p = 1'b1;
        @(negedge clk);
        start_p = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (busy_p) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL mid_latch_start: got busy=0, expected busy=1 within 20 cycles");
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (latch_p !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_latch_latch: got latch=%b, expected 1", latch_p);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({latch_p, pulse_p, buttons_p, valid_p, busy_p} !== {2'b00, 8'hFF, 2'b00}) begin
            n_bad++;
            $display("FAIL mid_latch_reset: got latch=%b pulse=%b buttons=%h valid=%b busy=%b, expected 0 0 ff 0 0",
                     latch_p, pulse_p, buttons_p, valid_p, busy_p);
        end
        repeat (3) begin
            @(negedge clk);
            if (valid_p || busy_p || latch_p) bad_seen = 1'b1;
        end
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (valid_p || busy_p || latch_p || buttons_p !== 8'hFF) bad_seen = 1'b1;
        end
        n_cmp++;
        if (bad_seen) begin
            n_bad++;
            $display("FAIL mid_latch_after: got activity after aborted frame, expected idle with buttons=ff");
        end
    endtask

    task automatic test_no_pad();
        int k;
        int gap;
        int bh;
        k = 0;
        while (!valid_p && k < 400) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (!valid_p) begin
            n_bad++;
            $display("FAIL no_pad_first: got no valid in 400 cycles, expected a poll");
        end
        for (int f = 0; f < 3; f++) begin
            gap = 0;
            bh = 0;
            do begin
                @(negedge clk);
                gap++;
                if (busy_p) bh++;
            end while (!valid_p && gap < 400);
            n_cmp++;
            if (gap !== POLL_P) begin
                n_bad++;
                $display("FAIL no_pad_period: got %0d cycles between valids, expected %0d", gap, POLL_P);
            end
            n_cmp++;
            if (bh !== BUSY_LEN) begin
                n_bad++;
                $display("FAIL no_pad_busy: got busy for %0d cycles, expected %0d", bh, BUSY_LEN);
            end
            n_cmp++;
            if (buttons_p !== 8'hFF) begin
                n_bad++;
                $display("FAIL no_pad_buttons: got %h, expected ff", buttons_p);
            end
        end
    endtask

    task automatic test_single_frame();
        int lh, pr, br, va, bh, ov, bi;
        logic [7:0] btn;
        bit to;
        pad_byte = 8'b0111_1110;
        pulse_start_m();
        mon_m(lh, pr, br, va, bh, ov, bi, btn, to);
        n_cmp++;
        if (to || va !== FRAME_LEN - 1) begin
            n_bad++;
            $display("FAIL frame_valid_at: got valid at cycle %0d (timeout=%0b), expected %0d", va + 1, to, FRAME_LEN);
        end
        n_cmp++;
        if (lh !== 2*C) begin
            n_bad++;
            $display("FAIL frame_latch_len: got %0d, expected %0d", lh, 2*C);
        end
        n_cmp++;
        if (pr !== NB - 1 || br !== 0) begin
            n_bad++;
            $display("FAIL frame_pulses: got %0d pulses (%0d wrong length), expected %0d of %0d cycles", pr, br, NB - 1, C);
        end
        n_cmp++;
        if (bh !== BUSY_LEN) begin
            n_bad++;
            $display("FAIL frame_busy_len: got %0d, expected %0d", bh, BUSY_LEN);
        end
        n_cmp++;
        if (btn !== 8'h7E) begin
            n_bad++;
            $display("FAIL frame_buttons: got %h, expected 7e", btn);
        end
        n_cmp++;
        if (ov !== 0 || bi !== 0) begin
            n_bad++;
            $display("FAIL frame_protocol: got overlap=%0d idle_activity=%0d, expected 0 0", ov, bi);
        end
    endtask

    task automatic test_merge();
        int rises[$];
        int valids[$];
        logic pb;
        bit seen;
        seen = 1'b0;
        pulse_start_m();
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (busy_m) seen = 1'b1;
        end
        pb = busy_m;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (busy_m && !pb) rises.push_back(n);
            if (valid_m) valids.push_back(n);
            pb = busy_m;
            start_m = (n == 10) || (n == 50);
        end
        start_m = 1'b0;
        n_cmp++;
        if (!seen || valids.size() != 2) begin
            n_bad++;
            $display("FAIL merge_frames: got %0d valid strobes (started=%0b), expected 2", valids.size(), seen);
        end else begin
            n_cmp++;
            if (valids[0] != FRAME_LEN - 1 || valids[1] != 2*FRAME_LEN) begin
                n_bad++;
                $display("FAIL merge_valid_times: got %0d,%0d, expected %0d,%0d",
                         valids[0], valids[1], FRAME_LEN - 1, 2*FRAME_LEN);
            end
        end
        n_cmp++;
        if (rises.size() != 1) begin
            n_bad++;
            $display("FAIL merge_restarts: got %0d extra frame starts, expected 1", rises.size());
        end else begin
            n_cmp++;
            if (rises[0] != FRAME_LEN + 1) begin
                n_bad++;
                $display("FAIL merge_restart_time: got busy rise at %0d, expected %0d", rises[0], FRAME_LEN + 1);
            end
        end
    endtask

    // PAD_DATA falls at negedge flip_n of the frame. A bit sees the new value
    // only if the change precedes its sample edge by at least two cycles.
    task automatic test_sync_latency(input int flip_n);
        int n;
        bit seen;
        logic [7:0] exp;
        for (int j = 0; j < NB; j++)
            exp[NB-1-j] = (flip_n <= 9 + 2*C*j) ? 1'b0 : 1'b1;
        ovr_en = 1'b1;
        ovr_val = 1'b1;
        seen = 1'b0;
        pulse_start_m();
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (busy_m) seen = 1'b1;
        end
        n = 0;
        while (!valid_m && n < 200) begin
            if (n == flip_n) ovr_val = 1'b0;
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!valid_m || buttons_m !== exp) begin
            n_bad++;
            $display("FAIL sync_latency_%0d: got buttons=%h valid=%b, expected %h", flip_n, buttons_m, valid_m, exp);
        end
        ovr_en = 1'b0;
        ovr_val = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_random_frames();
        int lh, pr, br, va, bh, ov, bi;
        logic [7:0] btn;
        bit to;
        int e_btn, e_time, e_proto, e_pulse;
        e_btn = 0; e_time = 0; e_proto = 0; e_pulse = 0;
        for (int f = 0; f < NFRAMES; f++) begin
            pad_byte = 8'($urandom);
            pulse_start_m();
            mon_m(lh, pr, br, va, bh, ov, bi, btn, to);
            n_cmp++;
            if (to || btn !== pad_byte) begin
                n_bad++;
                e_btn++;
                if (e_btn <= 5)
                    $display("FAIL random_buttons[%0d]: got %h (timeout=%0b), expected %h", f, btn, to, pad_byte);
            end
            if (va != FRAME_LEN - 1 || lh != 2*C || bh != BUSY_LEN) e_time++;
            if (ov != 0 || bi != 0) e_proto++;
            if (pr != NB - 1 || br != 0) e_pulse++;
        end
        n_cmp++;
        if (e_proto != 0) begin
            n_bad++;
            $display("FAIL random_protocol: got %0d frames with LATCH+PULSE or idle PULSE, expected 0", e_proto);
        end
        n_cmp++;
        if (e_time != 0) begin
            n_bad++;
            $display("FAIL random_timing: got %0d frames with wrong latch/busy/valid timing, expected 0", e_time);
        end
        n_cmp++;
        if (e_pulse != 0) begin
            n_bad++;
            $display("FAIL random_pulses: got %0d frames with wrong pulse train, expected 0", e_pulse);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start_p = 1'b0;
        start_m = 1'b0;
        pad_one = 1'b1;
        ovr_en  = 1'b0;
        ovr_val = 1'b1;
        @(negedge clk);
        test_reset();
        test_reset_mid_latch();
        test_no_pad();
        test_single_frame();
        test_merge();
        test_sync_latency(10 + 2*C*3);
        test_sync_latency(9 + 2*C*3);
        test_sync_latency(8 + 2*C*3);
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
